sn76489_bus_if: RTL
===================

# sn76489_bus_if

Bus-side responder for one SN76489-compatible PSG. It samples the active-low chip-enable/write strobe pair on PSG clock-enable ticks and decodes the latch/data command byte protocol into the chip's eight tone, attenuation and noise registers. It drives READY low while a write is being absorbed. It sits inside each PSG instance, between the write strobe generator in the audio block and the tone/noise generators, which consume its register outputs.

## Interface
- READY_TICKS, 32, number of clk_en ticks READY is held low after an accepted write; legal range 1..255.
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  PSG clock enable, one clk_sys cycle wide.
- ce_n  in  1  chip enable, active low.
- wr_n  in  1  write strobe, active low.
- data_i  in  8  command byte.
- ready_o  out  1  high = idle and ready; low = write in progress.
- tone0_o, tone1_o, tone2_o  out  10 each  tone period registers.
- att0_o, att1_o, att2_o, att3_o  out  4 each  attenuation registers; att3 is noise; 4'hF = silent.
- noise_ctrl_o  out  3  noise control: bit2 = white/periodic, bits1:0 = rate.
- noise_rst_o  out  1  one-clk_sys pulse on any write to the noise control register.

## Operation
- Reset values: ready_o=1, all tone*_o=0, all att*_o=4'hF, noise_ctrl_o=0, noise_rst_o=0, latched register index=0, FSM=IDLE.
- Strobe: `ce_n==0 && wr_n==0`, sampled only on cycles where clk_en=1.
- FSM states:
  - IDLE: on a tick with the strobe active, accept data_i and go to BUSY.
  - BUSY: ready_o=0. Count clk_en ticks. On the READY_TICKS-th tick after acceptance, go to WAIT_REL if the strobe is still active, otherwise go to IDLE.
  - WAIT_REL: ready_o=1. Go to IDLE on the first tick with the strobe inactive.
- One strobe assertion produces exactly one write. Strobes seen in BUSY or WAIT_REL are ignored; the byte is not queued.
- Decode when data_i[7]=1 (latch byte):
  - Latched index = data_i[6:4]. Index map: 0/2/4 = tone0/1/2, 1/3/5 = att0/1/2, 6 = noise control, 7 = att3.
  - Tone target: bits[3:0] = data_i[3:0].
  - Attenuation target: all 4 bits = data_i[3:0].
  - Noise target: noise_ctrl = data_i[2:0].
- Decode when data_i[7]=0 (data byte), using the latched index:
  - Tone target: bits[9:4] = data_i[5:0]; bits[3:0] are kept.
  - Attenuation target: data_i[3:0].
  - Noise target: data_i[2:0].
- noise_rst_o pulses for any write that lands in the noise control register, whether from a latch byte or a data byte.
- Register outputs are plain flops and are updated on the accepting edge only.

## Timing
- Acceptance edge is the clk_sys edge with clk_en=1 and the strobe active in IDLE. On that edge:
  - the target register updates,
  - noise_rst_o goes to 1,
  - ready_o goes to 0.
- All three are visible in the following cycle.
- noise_rst_o returns to 0 one clk_sys cycle later.
- ready_o returns to 1 on the edge of the READY_TICKS-th subsequent clk_en tick. It is low for exactly READY_TICKS clk_en periods.
- Earliest next acceptance is the first tick after ready_o rises with the strobe re-asserted. If the strobe was held continuously, the earliest next acceptance is after a release tick has been observed.
- clk_en stuck at 0: the FSM and counter freeze and ready_o holds its current value.
- Asserting reset_n low mid-BUSY clears the state immediately and asynchronously: ready_o=1 and every register returns to its reset value. The write in flight is not restarted.
- A strobe arriving in the same cycle that reset is deasserted is not accepted until the next clk_en tick.

## Configuration
- PSG_INSTANT_READY_EN defined:
  - BUSY is bypassed and ready_o is tied to 1.
  - An accepted write goes IDLE→WAIT_REL.
  - Back-to-back writes are accepted on every other tick if the strobe toggles.
  - READY_TICKS is unused.
- PSG_INSTANT_READY_EN undefined: the behaviour described above, with the READY_TICKS handshake.

## Test plan
- Write 0x8A, then 0x3F, each strobe held for 1 tick with waits for ready -> tone0_o=10'h3FA; all other outputs stay at reset values.
- Write 0x9F, then 0xB3 -> att0_o=4'hF, att1_o=4'h3; ready_o low for exactly 32 clk_en ticks after each acceptance.
- Write 0xE5 -> noise_ctrl_o=3'b101 and noise_rst_o high for exactly 1 clk_sys cycle. Then data byte 0x02 -> noise_ctrl_o=3'b010 with a second pulse.
- Hold the strobe active for 40 ticks with data 0xC7 -> exactly one write (tone2_o[3:0]=7); the FSM stays in WAIT_REL until release. Strobe 0xFF during BUSY -> att3_o unchanged.
- Assert reset_n low 10 ticks into BUSY -> ready_o=1 and tone0_o=0 immediately, with no clk_sys edge required.
- With PSG_INSTANT_READY_EN defined: strobes 0x81, 0x01 on alternating ticks -> ready_o never drops and tone0_o=10'h011.

Source files
------------

// File: rtl/sn76489_bus_if.sv
// sn76489_bus_if: bus-side write responder for one SN76489-compatible PSG.
// Samples the ce_n/wr_n strobe on clk_en ticks, decodes latch/data command
// bytes into the tone/attenuation/noise registers and throttles the writer
// through ready_o.
// Optional feature macro: PSG_INSTANT_READY_EN (skip the BUSY hold, ready_o tied high).
module sn76489_bus_if #(
   parameter int unsigned READY_TICKS = 32
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       clk_en,
   input  logic       ce_n,
   input  logic       wr_n,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic [9:0] tone0_o,
   output logic [9:0] tone1_o,
   output logic [9:0] tone2_o,
   output logic [3:0] att0_o,
   output logic [3:0] att1_o,
   output logic [3:0] att2_o,
   output logic [3:0] att3_o,
   output logic [2:0] noise_ctrl_o,
   output logic       noise_rst_o
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_BUSY     = 2'd1;
   localparam logic [1:0] S_WAIT_REL = 2'd2;

   logic [1:0] r_state;
   logic [2:0] r_idx;
   logic [9:0] r_tone0, r_tone1, r_tone2;
   logic [3:0] r_att0, r_att1, r_att2, r_att3;
   logic [2:0] r_noise;
   logic       r_noise_rst;

   logic       w_strobe;
   logic       w_accept;
   logic       w_latch;
   logic [2:0] w_idx;

   assign w_strobe = ~ce_n & ~wr_n;
   assign w_accept = clk_en & w_strobe & (r_state == S_IDLE);
   assign w_latch  = data_i[7];
   // Data bytes reuse the index captured by the most recent latch byte.
   assign w_idx    = w_latch ? data_i[6:4] : r_idx;

`ifdef PSG_INSTANT_READY_EN
   assign ready_o = 1'b1;

   // Handshake FSM: accept in IDLE, then wait for strobe release.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else if (clk_en) begin
         case (r_state)
            S_IDLE:     if (w_strobe) r_state <= S_WAIT_REL;
            S_WAIT_REL: if (!w_strobe) r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end
`else
   localparam logic [7:0] L_LAST_TICK = 8'(READY_TICKS - 1);

   logic [7:0] r_cnt;

   assign ready_o = (r_state != S_BUSY);

   // Handshake FSM: accept in IDLE, hold BUSY for READY_TICKS ticks, then
   // require a release tick before the next write can be accepted.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else if (clk_en) begin
         case (r_state)
            S_IDLE: begin
               if (w_strobe) begin
                  r_state <= S_BUSY;
                  r_cnt   <= 8'd0;
               end
            end
            S_BUSY: begin
               if (r_cnt == L_LAST_TICK) begin
                  r_state <= w_strobe ? S_WAIT_REL : S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_WAIT_REL: if (!w_strobe) r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end
`endif

   // Register file: updated only on the accepting edge.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_idx       <= 3'd0;
         r_tone0     <= 10'd0;
         r_tone1     <= 10'd0;
         r_tone2     <= 10'd0;
         r_att0      <= 4'hF;
         r_att1      <= 4'hF;
         r_att2      <= 4'hF;
         r_att3      <= 4'hF;
         r_noise     <= 3'd0;
         r_noise_rst <= 1'b0;
      end else begin
         r_noise_rst <= 1'b0;
         if (w_accept) begin
            if (w_latch) r_idx <= data_i[6:4];
            case (w_idx)
               3'd0: if (w_latch) r_tone0[3:0] <= data_i[3:0]; else r_tone0[9:4] <= data_i[5:0];
               3'd2: if (w_latch) r_tone1[3:0] <= data_i[3:0]; else r_tone1[9:4] <= data_i[5:0];
               3'd4: if (w_latch) r_tone2[3:0] <= data_i[3:0]; else r_tone2[9:4] <= data_i[5:0];
               3'd1: r_att0 <= data_i[3:0];
               3'd3: r_att1 <= data_i[3:0];
               3'd5: r_att2 <= data_i[3:0];
               3'd7: r_att3 <= data_i[3:0];
               default: begin
                  r_noise     <= data_i[2:0];
                  r_noise_rst <= 1'b1;
               end
            endcase
         end
      end
   end

   assign tone0_o      = r_tone0;
   assign tone1_o      = r_tone1;
   assign tone2_o      = r_tone2;
   assign att0_o       = r_att0;
   assign att1_o       = r_att1;
   assign att2_o       = r_att2;
   assign att3_o       = r_att3;
   assign noise_ctrl_o = r_noise;
   assign noise_rst_o  = r_noise_rst;

endmodule
